dma_xfer_ctrl: RTL
==================

# dma_xfer_ctrl

Single-channel transfer sequencer that drives the DMA register-style bus as a master. It takes a source (IO) address, destination (memory) address and word count from the configuration side, then moves data one word at a time: read from source, write to destination. It finishes with a sticky interrupt. It sits between the DMA control registers and the shared addr/wr_en/valid/wdata/rdata bus.

## Interface
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width
- LEN_WIDTH, 16, word-count width
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- cfg_start  input  1  one-cycle start pulse; accepted only in IDLE
- cfg_src  input  ADDR_WIDTH  source (IO) start address, sampled with cfg_start
- cfg_dst  input  ADDR_WIDTH  destination (memory) start address, sampled with cfg_start
- cfg_len  input  LEN_WIDTH  number of words, sampled with cfg_start
- abort  input  1  stop request, level or pulse
- intr_clr  input  1  clears intr and aborted
- bus_addr  output  ADDR_WIDTH  bus address
- bus_wr_en  output  1  1 = write beat, 0 = read beat
- bus_valid  output  1  beat request
- bus_wdata  output  DATA_WIDTH  write data
- bus_rdata  input  DATA_WIDTH  read data, valid in the cycle bus_ready=1 on a read beat
- bus_ready  input  1  slave accepts the beat in this cycle
- busy  output  1  high from the cycle after an accepted start until DONE
- intr  output  1  sticky completion interrupt
- aborted  output  1  sticky; set with intr when the transfer ended by abort
- words_done  output  LEN_WIDTH  words fully written in the current or last transfer

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: on cfg_start, latch cfg_src, cfg_dst and cfg_len, and clear words_done.
  - If cfg_len==0, go to DONE; otherwise go to RD.
  - cfg_start in any other state is ignored; no latch occurs.
- RD: drive bus_valid=1, bus_wr_en=0, bus_addr=src_ptr.
  - On bus_ready, capture bus_rdata into the data register, add 4 to src_ptr, and go to WR.
- WR: drive bus_valid=1, bus_wr_en=1, bus_addr=dst_ptr, bus_wdata=data register.
  - On bus_ready, add 4 to dst_ptr and add 1 to words_done.
  - Go to DONE if words_done+1==len or an abort is pending; otherwise go to RD.
- DONE: one cycle. Set intr=1, set aborted=abort_pend, clear abort_pend, and go to IDLE.
- Abort handling:
  - abort high in RD, WR or DONE sets abort_pend.
  - An in-flight beat is never dropped; bus_valid stays asserted until bus_ready.
  - Abort seen in RD: the current read completes, then WR completes, then DONE. The word in flight is always written.
  - abort in IDLE has no effect.
- Arithmetic: pointers wrap modulo 2^ADDR_WIDTH; no boundary check. words_done never exceeds len.
- intr_clr clears intr and aborted. If DONE sets intr in the same cycle as intr_clr, the set wins.

## Timing
- Reset values: all outputs 0; state IDLE; pointers, data register, len and abort_pend all 0. Reset in mid-transfer returns to IDLE at once and drops bus_valid asynchronously.
- Bus handshake:
  - bus_addr, bus_wr_en and bus_wdata are stable while bus_valid=1 && bus_ready=0.
  - A beat completes on the rising edge where bus_valid && bus_ready.
  - Outputs are registered; bus_valid is a function of state only.
- Latency:
  - cfg_start at edge 0 means RD at cycle 1.
  - With bus_ready held at 1, each word takes 2 cycles: RD then WR.
  - DONE follows the last WR by one cycle, and intr is visible the cycle after DONE.
  - An N-word transfer with no stalls has cfg_start→intr = 2N+2 cycles.
- len==0: cfg_start, then DONE at cycle 1, then intr at cycle 2, with no bus beats.
- busy=1 in RD, WR and DONE; 0 in IDLE.

## Test plan
- Basic transfer: src=0x400, dst=0x1000, len=3, ready always 1, slave returns 0xA0/0xA1/0xA2.
  - Expect beats R400, W1000=A0, R404, W1004=A1, R408, W1008=A2.
  - Expect intr at cycle 8 and words_done=3.
- Slave stalls: same setup, with ready low for 3 cycles on each beat.
  - Address, wr_en and wdata must hold stable during each stall.
  - Expect intr at cycle 8+18=26.
- Zero length: len=0.
  - Expect no bus_valid, intr at cycle 2, words_done=0, aborted=0.
- Abort mid-beat: len=4, abort pulsed during the 2nd read while it is stalled.
  - The 2nd read and 2nd write complete, then no further beats.
  - Expect intr=1, aborted=1, words_done=2.
- Restart and clear rules:
  - cfg_start during busy is ignored; the original transfer completes.
  - intr_clr then clears intr and aborted, and a new start is accepted.
  - intr_clr coincident with DONE leaves intr=1.
- Reset mid-transfer: assert reset during WR with ready low.
  - bus_valid drops without waiting for a clock; busy=0 and intr=0.
  - A following len=1 transfer completes normally.

Source files
------------

// File: rtl/dma_xfer_ctrl_if.sv
// Register-style DMA bus: one beat per valid/ready handshake, read or write
// selected by wr_en. The master holds addr/wr_en/wdata steady until ready.
interface dma_xfer_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  valid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (
        output addr,
        output wr_en,
        output valid,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  valid,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer: copies len words from an IO source to memory,
// one read beat then one write beat per word, ending with a sticky interrupt.
module dma_xfer_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_src,
    input  logic [ADDR_WIDTH-1:0] cfg_dst,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  abort,
    input  logic                  intr_clr,
    dma_xfer_ctrl_if.master       bus,
    output logic                  busy,
    output logic                  intr,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  words_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [DATA_WIDTH-1:0] data_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  abort_pend;
    logic                  last_word;
    logic                  stop_after_wr;

    assign last_word     = (words_done + LEN_WIDTH'(1)) == len_q;
    // An abort arriving in the same cycle as the write handshake still ends the run.
    assign stop_after_wr = last_word || abort_pend || abort;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (bus.ready) begin
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (bus.ready) begin
                    state_nxt = stop_after_wr ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus outputs decode the state register only, so reset drops valid at once.
    assign bus.valid = (state == S_RD) || (state == S_WR);
    assign bus.wr_en = (state == S_WR);
    assign bus.addr  = (state == S_WR) ? dst_ptr :
                       (state == S_RD) ? src_ptr : '0;
    assign bus.wdata = (state == S_WR) ? data_q : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ptr    <= '0;
            dst_ptr    <= '0;
            data_q     <= '0;
            len_q      <= '0;
            words_done <= '0;
            abort_pend <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        src_ptr    <= cfg_src;
                        dst_ptr    <= cfg_dst;
                        len_q      <= cfg_len;
                        words_done <= '0;
                        abort_pend <= 1'b0;
                    end
                end
                S_RD: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (bus.ready) begin
                        data_q  <= bus.rdata;
                        src_ptr <= src_ptr + WORD_BYTES;
                    end
                end
                S_WR: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (bus.ready) begin
                        dst_ptr    <= dst_ptr + WORD_BYTES;
                        words_done <= words_done + LEN_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    // The run is already over here; a late abort has nothing left to stop.
                    abort_pend <= 1'b0;
                end
                default: begin
                    abort_pend <= 1'b0;
                end
            endcase
        end
    end

    // Completion flags: setting from DONE takes priority over a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intr    <= 1'b0;
            aborted <= 1'b0;
        end else if (state == S_DONE) begin
            intr    <= 1'b1;
            aborted <= abort_pend;
        end else if (intr_clr) begin
            intr    <= 1'b0;
            aborted <= 1'b0;
        end
    end

    a_hold_during_stall : assert property (
        @(posedge clk) disable iff (!reset)
        (bus.valid && !bus.ready) |=>
            (bus.valid && $stable(bus.addr) && $stable(bus.wr_en) && $stable(bus.wdata))
    );

    a_words_bounded : assert property (
        @(posedge clk) disable iff (!reset)
        words_done <= len_q
    );

endmodule
